// File: rtl/uart_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_port_arbiter_if
//   One CSR bus port as used around the UART port arbiter. Each requester
//   (CPU data port, debug/loader engine) and the UART CSR slave side are all
//   instances of this interface.
//
//   Signals
//     stb   request strobe, held by the master until ack
//     we    write enable
//     adr   32-bit address
//     wdat  32-bit write data (master -> slave)
//     rdat  32-bit read data (slave -> master), valid with ack
//     ack   completion
//     err   error completion, coincident with ack
//
//   Modports
//     master  the side that issues requests
//     slave   the side that answers them
// -----------------------------------------------------------------------------
interface uart_port_arbiter_if;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;
    logic        err;

    modport master (
        output stb,
        output we,
        output adr,
        output wdat,
        input  rdat,
        input  ack,
        input  err
    );

    modport slave (
        input  stb,
        input  we,
        input  adr,
        input  wdat,
        output rdat,
        output ack,
        output err
    );
endinterface

// File: rtl/uart_port_arbiter.sv
// -----------------------------------------------------------------------------
// uart_port_arbiter
//   Shares the single CSR slave port of the UART between two requesters:
//   m0 is the CPU data port, m1 the debug/loader engine. Requests are
//   arbitrated round-robin, the winner's request is latched and driven to the
//   UART, and the UART ack (which stalls while its TX FIFO is full) is turned
//   into a registered one-cycle ack with read data back to the winner. A
//   watchdog ends a stalled transfer with an error completion.
//
//   Ports
//     sys_clk      clock, rising edge
//     sys_rst      asynchronous, active-high reset
//     m0           requester 0 bus (slave side of the interface)
//     m1           requester 1 bus (slave side of the interface)
//     s            UART CSR bus (master side of the interface);
//                  s.ack is combinational from s.stb, s.rdat is valid the
//                  edge after ack; s.err is not used by the UART
//     busy_o       high whenever a transfer is in flight (state != IDLE)
//     timeout_cnt  saturating count of watchdog completions (sticks at 255)
//
//   Parameters
//     TIMEOUT      max cycles spent in BUSY before a forced error completion
//                  (2..65535)
//
//   State | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no transfer; pick a winner from the sampled strobes
//   BUSY  | winner's request driven to the UART, waiting for ack or timeout
//   RESP  | capture UART read data and pulse ack/err back to the winner
// -----------------------------------------------------------------------------
module uart_port_arbiter #(
    parameter int TIMEOUT = 65535
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    uart_port_arbiter_if.slave    m0,
    uart_port_arbiter_if.slave    m1,
    uart_port_arbiter_if.master   s,
    output logic                  busy_o,
    output logic [7:0]            timeout_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Timer leaves BUSY on this value, so a 16-bit timer can never wrap.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        err_q, err_d;

    logic        s_stb_q, s_stb_d;
    logic        s_we_q, s_we_d;
    logic [31:0] s_adr_q, s_adr_d;
    logic [31:0] s_dat_q, s_dat_d;

    logic [31:0] m0_dat_q, m0_dat_d;
    logic        m0_ack_q, m0_ack_d;
    logic        m0_err_q, m0_err_d;
    logic [31:0] m1_dat_q, m1_dat_d;
    logic        m1_ack_q, m1_ack_d;
    logic        m1_err_q, m1_err_d;

    logic [7:0]  timeout_cnt_q, timeout_cnt_d;

    logic        gnt;
    logic [31:0] resp_dat;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            last_grant_q  <= 1'b1;   // so m0 wins the first tie
            grant_q       <= 1'b0;
            err_q         <= 1'b0;
            s_stb_q       <= 1'b0;
            s_we_q        <= 1'b0;
            s_adr_q       <= '0;
            s_dat_q       <= '0;
            m0_dat_q      <= '0;
            m0_ack_q      <= 1'b0;
            m0_err_q      <= 1'b0;
            m1_dat_q      <= '0;
            m1_ack_q      <= 1'b0;
            m1_err_q      <= 1'b0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            err_q         <= err_d;
            s_stb_q       <= s_stb_d;
            s_we_q        <= s_we_d;
            s_adr_q       <= s_adr_d;
            s_dat_q       <= s_dat_d;
            m0_dat_q      <= m0_dat_d;
            m0_ack_q      <= m0_ack_d;
            m0_err_q      <= m0_err_d;
            m1_dat_q      <= m1_dat_d;
            m1_ack_q      <= m1_ack_d;
            m1_err_q      <= m1_err_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        err_d         = err_q;
        s_stb_d       = s_stb_q;
        s_we_d        = s_we_q;
        s_adr_d       = s_adr_q;
        s_dat_d       = s_dat_q;
        m0_dat_d      = m0_dat_q;
        m0_ack_d      = 1'b0;
        m0_err_d      = 1'b0;
        m1_dat_d      = m1_dat_q;
        m1_ack_d      = 1'b0;
        m1_err_d      = 1'b0;
        timeout_cnt_d = timeout_cnt_q;
        gnt           = 1'b0;
        resp_dat      = '0;

        case (state_q)
            ST_IDLE: begin
                s_stb_d = 1'b0;
                if (m0.stb || m1.stb) begin
                    // A lone requester wins outright; on a tie the one that
                    // did not win last time goes.
                    gnt          = (m0.stb && m1.stb) ? ~last_grant_q : m1.stb;
                    grant_d      = gnt;
                    last_grant_d = gnt;
                    s_we_d       = gnt ? m1.we   : m0.we;
                    s_adr_d      = gnt ? m1.adr  : m0.adr;
                    s_dat_d      = gnt ? m1.wdat : m0.wdat;
                    s_stb_d      = 1'b1;
                    timer_d      = '0;
                    err_d        = 1'b0;
                    state_d      = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // Ack takes priority over a coincident timeout.
                if (s.ack) begin
                    s_stb_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    s_stb_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                    if (timeout_cnt_q != 8'hFF) begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            ST_RESP: begin
                // The UART presents read data one edge after its ack; writes
                // and error completions return zero.
                resp_dat = (s_we_q || err_q) ? 32'h0 : s.rdat;
                if (grant_q) begin
                    m1_dat_d = resp_dat;
                    m1_ack_d = 1'b1;
                    m1_err_d = err_q;
                end else begin
                    m0_dat_d = resp_dat;
                    m0_ack_d = 1'b1;
                    m0_err_d = err_q;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s.stb       = s_stb_q;
    assign s.we        = s_we_q;
    assign s.adr       = s_adr_q;
    assign s.wdat      = s_dat_q;

    assign m0.rdat     = m0_dat_q;
    assign m0.ack      = m0_ack_q;
    assign m0.err      = m0_err_q;
    assign m1.rdat     = m1_dat_q;
    assign m1.ack      = m1_ack_q;
    assign m1.err      = m1_err_q;

    assign busy_o      = (state_q != ST_IDLE);
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_uart_port_arbiter.sv
module tb_uart_port_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        s_ack_en = 1'b0;
    logic [31:0] s_rdat_v = 32'h0;
    logic        busy;
    logic [7:0]  tcnt;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 sys_clk = ~sys_clk;

    uart_port_arbiter_if m0_bus ();
    uart_port_arbiter_if m1_bus ();
    uart_port_arbiter_if s_bus ();

    // UART model: ack is combinational from stb unless stalled.
    assign s_bus.ack  = s_bus.stb & s_ack_en;
    assign s_bus.rdat = s_rdat_v;
    assign s_bus.err  = 1'b0;

    uart_port_arbiter #(.TIMEOUT(16)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .s           (s_bus),
        .busy_o      (busy),
        .timeout_cnt (tcnt)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge sys_clk);
    endtask

    task automatic set_m0(input logic stb, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m0_bus.stb  = stb;
        m0_bus.we   = we;
        m0_bus.adr  = adr;
        m0_bus.wdat = dat;
    endtask

    task automatic set_m1(input logic stb, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m1_bus.stb  = stb;
        m1_bus.we   = we;
        m1_bus.adr  = adr;
        m1_bus.wdat = dat;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n_hi;
        int n_lost;
        logic got;
        logic e0, e1;

        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);

        // ---------------- reset state
        tick; tick;
        check("rst_busy", busy, 1'b0);
        check("rst_s_bus", {s_bus.stb, s_bus.we, s_bus.adr, s_bus.wdat}, 66'h0);
        check("rst_m0", {m0_bus.ack, m0_bus.err, m0_bus.rdat}, 34'h0);
        check("rst_m1", {m1_bus.ack, m1_bus.err, m1_bus.rdat}, 34'h0);
        check("rst_tcnt", tcnt, 8'h0);
        sys_rst = 1'b0;
        tick;

        // ---------------- case 1: m0 write, no stall
        s_ack_en = 1'b1;
        set_m0(1'b1, 1'b1, 32'h0, 32'h41);
        tick;
        check("t1_s_bus", {s_bus.stb, s_bus.we, s_bus.adr, s_bus.wdat}, {1'b1, 1'b1, 32'h0, 32'h41});
        check("t1_ack_early", m0_bus.ack, 1'b0);
        m0_bus.stb = 1'b0;
        tick;
        check("t1_stb_drop", {s_bus.stb, busy}, 2'b01);
        tick;
        check("t1_ack", {m0_bus.ack, m0_bus.err, m0_bus.rdat}, {1'b1, 1'b0, 32'h0});
        tick;
        check("t1_ack_pulse", {m0_bus.ack, busy}, 2'b00);

        // ---------------- case 2: m1 read, data captured on the RESP edge
        s_rdat_v = 32'h0BAD;
        set_m1(1'b1, 1'b0, 32'h10, 32'h0);
        tick;
        check("t2_s_bus", {s_bus.stb, s_bus.we, s_bus.adr}, {1'b1, 1'b0, 32'h10});
        m1_bus.stb = 1'b0;
        tick;
        s_rdat_v = 32'h1C3;
        tick;
        check("t2_m1_ack", {m1_bus.ack, m1_bus.err, m1_bus.rdat}, {1'b1, 1'b0, 32'h1C3});
        check("t2_m0_quiet", {m0_bus.ack, m0_bus.err, m0_bus.rdat}, 34'h0);
        tick;
        check("t2_m1_hold", {m1_bus.ack, m1_bus.rdat}, {1'b0, 32'h1C3});

        // ---------------- case 4: 10 stall cycles
        s_ack_en = 1'b0;
        set_m0(1'b1, 1'b1, 32'h4, 32'h55);
        tick;
        for (int c = 0; c < 10; c++) begin
            check("t4_hold", {s_bus.stb, s_bus.we, s_bus.adr, s_bus.wdat}, {1'b1, 1'b1, 32'h4, 32'h55});
            if (c == 0) m0_bus.stb = 1'b0;
            tick;
        end
        check("t4_hold_last", {s_bus.stb, s_bus.adr, m0_bus.ack}, {1'b1, 32'h4, 1'b0});
        s_ack_en = 1'b1;
        tick;
        check("t4_no_ack_yet", {s_bus.stb, m0_bus.ack}, 2'b00);
        tick;
        check("t4_ack", {m0_bus.ack, m0_bus.err}, 2'b10);
        tick;

        // ---------------- case 3: both requesting from reset, 4 transfers
        sys_rst = 1'b1;
        tick;
        s_rdat_v = 32'h77;
        set_m0(1'b1, 1'b0, 32'h100, 32'h0);
        set_m1(1'b1, 1'b0, 32'h200, 32'h0);
        sys_rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick;
            e0 = (c == 2) || (c == 8);
            e1 = (c == 5) || (c == 11);
            check("t3_acks", {m0_bus.ack, m1_bus.ack}, {e0, e1});
            if ((c % 3) == 0)
                check("t3_grant", {s_bus.stb, s_bus.adr}, {1'b1, ((c % 6) == 0) ? 32'h100 : 32'h200});
        end
        m0_bus.stb = 1'b0;
        m1_bus.stb = 1'b0;
        tick; tick;
        check("t3_idle", busy, 1'b0);
        check("t3_rdat", {m0_bus.rdat, m1_bus.rdat}, {32'h77, 32'h77});

        // ---------------- case 5: watchdog
        s_ack_en = 1'b0;
        set_m0(1'b1, 1'b0, 32'h8, 32'h0);
        tick;
        m0_bus.stb = 1'b0;
        n_hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (!s_bus.stb) break;
            n_hi++;
            tick;
        end
        check("t5_stb_cycles", n_hi, 16);
        tick;
        check("t5_err_ack", {m0_bus.ack, m0_bus.err, m0_bus.rdat}, {1'b1, 1'b1, 32'h0});
        check("t5_tcnt1", tcnt, 8'd1);
        n_lost = 0;
        for (int k = 0; k < 299; k++) begin
            m0_bus.stb = 1'b1;
            tick;
            m0_bus.stb = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                tick;
                if (m0_bus.ack) got = 1'b1;
            end
            if (!got) n_lost++;
            if (k == 252) check("t5_tcnt254", tcnt, 8'd254);
            if (k == 253) check("t5_tcnt255", tcnt, 8'd255);
        end
        check("t5_lost", n_lost, 0);
        check("t5_tcnt_sat", tcnt, 8'd255);

        // ---------------- case 6: reset mid-BUSY
        set_m0(1'b1, 1'b1, 32'hC, 32'h99);
        tick;
        m0_bus.stb = 1'b0;
        tick; tick;
        check("t6_in_busy", {busy, s_bus.stb}, 2'b11);
        #1 sys_rst = 1'b1;
        #1;
        check("t6_async_busy", {busy, tcnt}, 9'h0);
        check("t6_async_s", {s_bus.stb, s_bus.we, s_bus.adr, s_bus.wdat}, 66'h0);
        check("t6_async_m", {m0_bus.ack, m0_bus.err, m0_bus.rdat, m1_bus.ack, m1_bus.err, m1_bus.rdat}, 68'h0);
        tick;
        s_ack_en = 1'b1;
        set_m0(1'b1, 1'b0, 32'h300, 32'h0);
        set_m1(1'b1, 1'b0, 32'h400, 32'h0);
        sys_rst = 1'b0;
        tick;
        check("t6_first_grant", {s_bus.stb, s_bus.adr}, {1'b1, 32'h300});
        m0_bus.stb = 1'b0;
        m1_bus.stb = 1'b0;
        tick; tick;
        check("t6_ack", {m0_bus.ack, m1_bus.ack}, 2'b10);
        tick; tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
